// File: rtl/itch_feed_arbiter.sv
// Two-channel length-prefixed byte stream arbiter feeding the one-byte-per-cycle ITCH parser.
// Grants whole messages round-robin, strips the 16-bit length, drops empty/oversize messages.
module itch_feed_arbiter #(
  parameter int unsigned MAX_LEN    = 64,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic [7:0]  s0_byte,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_byte,
  output logic        s1_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_src,
  output logic        busy,
  output logic [31:0] msg_count,
  output logic [15:0] drop_count
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, PAYLOAD, DROP, GAP} state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               first_q, first_d;
  logic               s0_ready_q, s0_ready_d;
  logic               s1_ready_q, s1_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic               out_src_q, out_src_d;
  logic               busy_q, busy_d;
  logic [31:0]        msg_count_q, msg_count_d;
  logic [15:0]        drop_count_q, drop_count_d;

  logic               xfer;
  logic [7:0]         sel_byte;
  logic [LEN_W-1:0]   len_full;
  logic               channel_state;

  // Next state, datapath and registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_hi_d     = len_hi_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    first_d      = first_q;
    out_valid_d  = 1'b0;
    out_byte_d   = out_byte_q;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    out_src_d    = out_src_q;
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;

    xfer     = grant_q ? (s1_valid & s1_ready_q) : (s0_valid & s0_ready_q);
    sel_byte = grant_q ? s1_byte : s0_byte;
    len_full = {len_hi_q, sel_byte};

    unique case (state_q)
      IDLE: begin
        if (s0_valid | s1_valid) begin
          grant_d      = (s0_valid & s1_valid) ? ~last_grant_q : s1_valid;
          last_grant_d = grant_d;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_hi_d = sel_byte;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          if (len_full == '0) begin
            drop_count_d = drop_count_q + 16'd1;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_W'(GAP_CYCLES);
            end
          end else if (len_full > LEN_W'(MAX_LEN)) begin
            drop_count_d = drop_count_q + 16'd1;
            rem_d        = len_full;
            state_d      = DROP;
          end else begin
            rem_d   = len_full;
            first_d = 1'b1;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          out_valid_d = 1'b1;
          out_byte_d  = sel_byte;
          out_sop_d   = first_q;
          out_eop_d   = (rem_q == LEN_W'(1));
          out_src_d   = grant_q;
          first_d     = 1'b0;
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            msg_count_d = msg_count_q + 32'd1;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_W'(GAP_CYCLES);
            end
          end
        end
      end
      DROP: begin
        if (xfer) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_W'(GAP_CYCLES);
            end
          end
        end
      end
      GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered from the next state so only the locked channel is ever offered.
    channel_state = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                    (state_d == PAYLOAD) || (state_d == DROP);
    s0_ready_d    = channel_state & ~grant_d;
    s1_ready_d    = channel_state & grant_d;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_hi_q     <= '0;
      rem_q        <= '0;
      gap_q        <= '0;
      first_q      <= 1'b0;
      s0_ready_q   <= 1'b0;
      s1_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_src_q    <= 1'b0;
      busy_q       <= 1'b0;
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_hi_q     <= len_hi_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      first_q      <= first_d;
      s0_ready_q   <= s0_ready_d;
      s1_ready_q   <= s1_ready_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_src_q    <= out_src_d;
      busy_q       <= busy_d;
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign s0_ready   = s0_ready_q;
  assign s1_ready   = s1_ready_q;
  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_src    = out_src_q;
  assign busy       = busy_q;
  assign msg_count  = msg_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/itch_feed_arbiter.md
Name: itch_feed_arbiter

Overview:
- Front-end controller for the one-byte-per-cycle ITCH parser.
- Takes two length-prefixed byte streams, each carrying a 2-byte big-endian length followed by one ITCH message (SoupBinTCP/MoldUDP64 style).
- Grants whole messages round-robin and strips the length prefix.
- Drives the payload bytes as the parser's valid_in/byte_in, with framing flags, source tag and error accounting.

Parameters:
- MAX_LEN, 64, largest accepted payload length in bytes; longer messages are consumed and discarded.
- GAP_CYCLES, 1, forced idle output cycles after each forwarded message (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- s0_valid  input  1  channel 0 byte valid
- s0_byte  input  8  channel 0 byte
- s0_ready  output  1  channel 0 byte accepted when s0_valid&s0_ready
- s1_valid  input  1  channel 1 byte valid
- s1_byte  input  8  channel 1 byte
- s1_ready  output  1  channel 1 byte accepted when s1_valid&s1_ready
- out_valid  output  1  payload byte valid; connects to parser valid_in
- out_byte  output  8  payload byte; connects to parser byte_in
- out_sop  output  1  first payload byte of a message
- out_eop  output  1  last payload byte of a message
- out_src  output  1  channel of the current message
- busy  output  1  state != IDLE
- msg_count  output  32  messages forwarded, wraps
- drop_count  output  16  zero-length plus oversize messages, wraps

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; last_grant=1, so ch0 wins the first contention; rem=0; gap counter 0.
- States: IDLE, LEN_HI, LEN_LO, PAYLOAD, DROP, GAP.
- IDLE:
  - s*_ready=0.
  - If any s*_valid: grant = the requesting channel; if both request, grant = !last_grant.
  - Register grant, set last_grant=grant, go to LEN_HI.
  - No request: stay in IDLE.
- In LEN_HI, LEN_LO, PAYLOAD and DROP:
  - Only the granted channel's ready=1; the other channel's ready=0.
  - The state advances only on a transfer (valid&ready).
  - The grant is locked until the message ends; the other channel cannot preempt it.
- LEN_HI: on transfer, len[15:8]=byte; go to LEN_LO.
- LEN_LO: on transfer, len[7:0]=byte, then on the full 16-bit length:
  - len==0: drop_count+1; go to GAP (or IDLE if GAP_CYCLES==0).
  - len>MAX_LEN: drop_count+1; rem=len; go to DROP.
  - Otherwise: rem=len; go to PAYLOAD.
- PAYLOAD, on transfer:
  - Next cycle out_valid=1, out_byte=byte, out_src=grant.
  - out_sop=1 on the first payload byte; out_eop=1 when rem==1.
  - rem-1.
  - On the rem==1 transfer: msg_count+1 (same cycle as out_eop); go to GAP or IDLE.
- Output latency is exactly 1 cycle from the accepted byte. out_* are registered.
- Bubbles:
  - If the granted valid is low, out_valid=0 next cycle and out_byte holds its value; sop/eop=0.
  - The parser holds its state while valid_in is low.
- DROP:
  - Consume bytes; rem-1 per transfer; out_valid stays 0.
  - On the rem==1 transfer, go to GAP or IDLE. msg_count is unchanged.
- GAP: hold for GAP_CYCLES cycles with all ready=0 and out_valid=0, then go to IDLE.
- Minimum spacing is one non-valid output cycle between consecutive messages, because IDLE costs one cycle.
- Width rules:
  - len and rem are 16 bits unsigned.
  - MAX_LEN compare is unsigned.
  - Counters wrap silently.
- Simultaneous events: a request from the non-granted channel while busy is ignored until IDLE. Round-robin applies only on simultaneous requests in IDLE.
- Reset mid-message:
  - Immediate return to IDLE; readies drop; the partial message is not completed.
  - out_eop is never issued for the partial message.
  - Upstream sources must restart on a length boundary.

Test Plan:
- Ch0 sends 00 03 41 42 43 -> out_valid on 3 cycles with bytes 41,42,43; sop on 41, eop on 43; out_src=0; msg_count=1; 1-cycle latency after each accept.
- Both channels continuously offer 00 01 xx messages -> grants alternate ch0, ch1, ch0, ch1; each message fully delivered before the next begins; ≥1+GAP_CYCLES idle out cycles between messages.
- Ch1 sends 00 00 then 00 01 55 -> drop_count=1; one message 55 forwarded with sop=eop=1; msg_count=1.
- Ch0 sends 00 41 (65 bytes, MAX_LEN=64) then 00 02 AA BB -> 65 bytes consumed with out_valid=0; drop_count=1; then AA,BB forwarded; msg_count=1.
- Ch0 payload 00 04 with s0_valid low for 2 cycles after the 2nd byte -> out_valid low for 2 cycles; bytes in order; eop on the 4th byte; s1 ignored meanwhile.
- rst asserted after 2 of 5 payload bytes -> all outputs 0 asynchronously; no eop; after release a fresh 00 01 77 on ch1 is forwarded correctly.
